// File: rtl/tlx_lane_trainer.sv
// -----------------------------------------------------------------------------
// tlx_lane_trainer
//
// TLX lane training engine. Drives a training pattern (PRBS7 or alternating
// 0/1) on NUM_TX forward lanes, muxed with registered functional data when no
// run is active. Checks NUM_RX reverse lanes with self-synchronising checkers
// and reports per-lane saturating error counts, lock status, a sticky DONE
// flag and a one-cycle completion interrupt.
//
// A run steps through IDLE -> SYNC (7 cycles) -> CHECK (RUN_LEN cycles) -> FIN.
// During SYNC the checkers only fill their receive history. Errors are counted
// only during CHECK.
//
// Ports:
//   TLX_CLK    in   clock
//   TLX_RESET  in   asynchronous active-high reset
//   MODE       in   00 bypass, 01 PRBS7, 10 alternating, 11 treated as bypass
//   START      in   single-cycle run request, accepted only in IDLE
//   RUN_LEN    in   number of CHECK cycles, latched with START
//   TX_IN      in   functional forward-lane data
//   TX_OUT     out  registered forward-lane data to the pads
//   RX_IN      in   reverse-lane bits
//   BUSY       out  run in progress
//   DONE       out  sticky: a run has completed since the last accepted START
//   LOCKED     out  per-lane pass result, updated in FIN
//   ERR_CNT    out  per-lane error counters, lane i at [i*CNT_W +: CNT_W]
//   TLX_INT    out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module tlx_lane_trainer #(
  parameter int         NUM_TX = 3,
  parameter int         NUM_RX = 3,
  parameter int         CNT_W  = 16,
  parameter logic [6:0] SEED   = 7'h7F
) (
  input  logic                    TLX_CLK,
  input  logic                    TLX_RESET,
  input  logic [1:0]              MODE,
  input  logic                    START,
  input  logic [CNT_W-1:0]        RUN_LEN,
  input  logic [NUM_TX-1:0]       TX_IN,
  output logic [NUM_TX-1:0]       TX_OUT,
  input  logic [NUM_RX-1:0]       RX_IN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [NUM_RX-1:0]       LOCKED,
  output logic [NUM_RX*CNT_W-1:0] ERR_CNT,
  output logic                    TLX_INT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Saturating increment for the error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         sync_cnt_q, sync_cnt_d;
  logic [CNT_W-1:0]   chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0]   run_len_q, run_len_d;
  logic               alt_mode_q, alt_mode_d;
  logic [6:0]         lfsr_q, lfsr_d;
  logic               alt_bit_q, alt_bit_d;
  logic [CNT_W-1:0]   err_cnt_q [NUM_RX];
  logic [CNT_W-1:0]   err_cnt_d [NUM_RX];
  logic [NUM_RX-1:0]  trans_q, trans_d;
  logic [NUM_RX-1:0]  locked_q, locked_d;
  logic               done_q, done_d;
  logic               int_q, int_d;
  logic               busy_q, busy_d;
  logic [NUM_TX-1:0]  tx_out_q, tx_out_d;
  logic [6:0]         hist_q [NUM_RX];
  logic [6:0]         hist_d [NUM_RX];

  logic               active;
  logic               fb;
  logic               gen_bit;
  logic [NUM_RX-1:0]  lane_err;

  // Per-lane checker decision. PRBS: the received bit must equal the PRBS7
  // recurrence over the history (odd lanes carry the inverted stream).
  // Alternating: the received bit must differ from the previous one.
  always_comb begin
    lane_err = '0;
    for (int i = 0; i < NUM_RX; i++) begin
      if (alt_mode_q) begin
        lane_err[i] = (RX_IN[i] == hist_q[i][0]);
      end else begin
        lane_err[i] = RX_IN[i] ^ hist_q[i][6] ^ hist_q[i][5] ^ i[0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    chk_cnt_d  = chk_cnt_q;
    run_len_d  = run_len_q;
    alt_mode_d = alt_mode_q;
    lfsr_d     = lfsr_q;
    alt_bit_d  = alt_bit_q;
    err_cnt_d  = err_cnt_q;
    trans_d    = trans_q;
    locked_d   = locked_q;
    done_d     = done_q;
    int_d      = 1'b0;
    busy_d     = 1'b0;
    tx_out_d   = TX_IN;
    hist_d     = hist_q;
    active     = 1'b0;
    fb         = lfsr_q[6] ^ lfsr_q[5];
    gen_bit    = alt_mode_q ? alt_bit_q : fb;

    case (state_q)
      ST_IDLE: begin
        if (START && (MODE == 2'b01 || MODE == 2'b10)) begin
          state_d    = ST_SYNC;
          sync_cnt_d = '0;
          chk_cnt_d  = '0;
          run_len_d  = RUN_LEN;
          alt_mode_d = (MODE == 2'b10);
          lfsr_d     = SEED;
          alt_bit_d  = 1'b0;
          err_cnt_d  = '{default: '0};
          trans_d    = '0;
          locked_d   = '0;
          done_d     = 1'b0;
        end
      end
      ST_SYNC: begin
        active     = 1'b1;
        sync_cnt_d = sync_cnt_q + 3'd1;
        if (sync_cnt_q == 3'd6) begin
          chk_cnt_d = '0;
          state_d   = (run_len_q == '0) ? ST_FIN : ST_CHECK;
        end
      end
      ST_CHECK: begin
        active    = 1'b1;
        chk_cnt_d = chk_cnt_q + CNT_W'(1);
        if (chk_cnt_q == run_len_q - CNT_W'(1)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        int_d   = 1'b1;
        // A lane passes only with zero errors and at least one transition,
        // so a lane stuck at a constant level never reports lock.
        for (int i = 0; i < NUM_RX; i++) begin
          locked_d[i] = (err_cnt_q[i] == '0) && trans_q[i];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (active) begin
      busy_d    = 1'b1;
      lfsr_d    = {lfsr_q[5:0], fb};
      alt_bit_d = ~alt_bit_q;
      for (int i = 0; i < NUM_TX; i++) begin
        tx_out_d[i] = gen_bit ^ i[0];
      end
      for (int i = 0; i < NUM_RX; i++) begin
        hist_d[i] = {hist_q[i][5:0], RX_IN[i]};
        if (state_q == ST_CHECK) begin
          if (lane_err[i]) begin
            err_cnt_d[i] = sat_inc(err_cnt_q[i]);
          end
          if (RX_IN[i] != hist_q[i][0]) begin
            trans_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge TLX_CLK or posedge TLX_RESET) begin
    if (TLX_RESET) begin
      state_q    <= ST_IDLE;
      sync_cnt_q <= '0;
      chk_cnt_q  <= '0;
      run_len_q  <= '0;
      alt_mode_q <= 1'b0;
      lfsr_q     <= SEED;
      alt_bit_q  <= 1'b0;
      err_cnt_q  <= '{default: '0};
      trans_q    <= '0;
      locked_q   <= '0;
      done_q     <= 1'b0;
      int_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      run_len_q  <= run_len_d;
      alt_mode_q <= alt_mode_d;
      lfsr_q     <= lfsr_d;
      alt_bit_q  <= alt_bit_d;
      err_cnt_q  <= err_cnt_d;
      trans_q    <= trans_d;
      locked_q   <= locked_d;
      done_q     <= done_d;
      int_q      <= int_d;
      busy_q     <= busy_d;
      tx_out_q   <= tx_out_d;
    end
  end

  // Receive history is pure data: SYNC refills all 7 bits before it is used.
  always_ff @(posedge TLX_CLK) begin
    hist_q <= hist_d;
  end

  always_comb begin
    ERR_CNT = '0;
    for (int i = 0; i < NUM_RX; i++) begin
      ERR_CNT[i*CNT_W +: CNT_W] = err_cnt_q[i];
    end
  end

  assign TX_OUT  = tx_out_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign LOCKED  = locked_q;
  assign TLX_INT = int_q;

endmodule
